// File: rtl/e1_pkg.sv
// Shared E1 receive definitions: default rates, LOS threshold and line symbol type.
package e1_pkg;

    localparam int unsigned E1_OSR          = 8;
    localparam int unsigned E1_LOS_DEFAULT  = 32;
    localparam int unsigned E1_SYNC_DEFAULT = 2;

    typedef enum logic [1:0] {
        SYM_ZERO = 2'd0,
        SYM_POS  = 2'd1,
        SYM_NEG  = 2'd2
    } sym_t;

    function automatic logic is_mark(input sym_t s);
        return s != SYM_ZERO;
    endfunction

endpackage

// File: rtl/e1_rx_bit_sync.sv
// Input synchronizers, bit timing recovery and per-cell symbol formation.
module e1_rx_bit_sync
    import e1_pkg::*;
#(
    parameter int unsigned OSR         = E1_OSR,
    parameter int unsigned SYNC_STAGES = E1_SYNC_DEFAULT
) (
    input  logic CLK,
    input  logic RST_N,
    input  logic rxp,
    input  logic rxn,
    output sym_t sym,
    output logic sym_valid,
    output logic both_err
);

    localparam int unsigned     PW      = $clog2(OSR);
    localparam logic [PW-1:0]   PH_LAST = PW'(OSR - 1);

    logic [SYNC_STAGES-1:0] sync_p_q, sync_p_d;
    logic [SYNC_STAGES-1:0] sync_n_q, sync_n_d;
    logic [PW-1:0]          phase_q, phase_d;
    logic                   any_q, any_d;
    logic                   seen_p_q, seen_p_d;
    logic                   seen_n_q, seen_n_d;
    logic                   rp, rn, edge_det, cell_close, cls_p, cls_n;

    // Next-state for synchronizers, phase counter and per-cell polarity flags.
    // On a close cycle that also carries an edge, the edge sample belongs to
    // the new cell, so it is excluded from the closing cell's flags.
    always_comb begin
        sync_p_d   = {sync_p_q[SYNC_STAGES-2:0], rxp};
        sync_n_d   = {sync_n_q[SYNC_STAGES-2:0], rxn};
        rp         = sync_p_q[SYNC_STAGES-1];
        rn         = sync_n_q[SYNC_STAGES-1];
        any_d      = rp | rn;
        edge_det   = (rp | rn) & ~any_q;
        cell_close = (phase_q == PH_LAST);
        phase_d    = edge_det ? PW'(1) : phase_q + PW'(1);
        cls_p      = seen_p_q | (rp & ~edge_det);
        cls_n      = seen_n_q | (rn & ~edge_det);
        if (cell_close) begin
            seen_p_d = edge_det & rp;
            seen_n_d = edge_det & rn;
        end else begin
            seen_p_d = seen_p_q | rp;
            seen_n_d = seen_n_q | rn;
        end
        sym_valid = cell_close;
        both_err  = cell_close & cls_p & cls_n;
        sym       = SYM_ZERO;
        if (cell_close) begin
            if (cls_p && !cls_n)      sym = SYM_POS;
            else if (cls_n && !cls_p) sym = SYM_NEG;
        end
    end

    // Timing-recovery state registers.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            sync_p_q <= '0;
            sync_n_q <= '0;
            phase_q  <= '0;
            any_q    <= 1'b0;
            seen_p_q <= 1'b0;
            seen_n_q <= 1'b0;
        end else begin
            sync_p_q <= sync_p_d;
            sync_n_q <= sync_n_d;
            phase_q  <= phase_d;
            any_q    <= any_d;
            seen_p_q <= seen_p_d;
            seen_n_q <= seen_n_d;
        end
    end

endmodule

// File: rtl/e1_rx_hdb3_decoder.sv
// E1 receive front-end: HDB3 substitution removal, code-error and LOS detection.
module e1_rx_hdb3_decoder
    import e1_pkg::*;
#(
    parameter int unsigned OSR         = E1_OSR,
    parameter int unsigned LOS_ZEROS   = E1_LOS_DEFAULT,
    parameter int unsigned SYNC_STAGES = E1_SYNC_DEFAULT
) (
    input  logic CLK,
    input  logic RST_N,
    input  logic rxp,
    input  logic rxn,
    output logic bit_valid,
    output logic bit_data,
    output logic code_err,
    output logic los
);

    sym_t       sym;
    logic       sym_valid, both_err;
    sym_t       s_q [4];
    sym_t       s_d [4];
    sym_t       w   [4];
    logic       last_neg_q, last_neg_d;
    logic       v_seen_q, v_seen_d;
    logic       last_v_neg_q, last_v_neg_d;
    logic [2:0] fill_q, fill_d;
    logic [7:0] zcnt_q, zcnt_d;
    logic       los_q, los_d;
    logic       bit_valid_q, bit_valid_d;
    logic       bit_data_q, bit_data_d;
    logic       code_err_q, code_err_d;
    logic       mark, sym_neg, is_v, v_err;

    e1_rx_bit_sync #(
        .OSR         (OSR),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_bit_sync (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .rxp       (rxp),
        .rxn       (rxn),
        .sym       (sym),
        .sym_valid (sym_valid),
        .both_err  (both_err)
    );

    // On each cell close: shift the symbol window, strip V/B substitution
    // pulses, check HDB3 rules, track zero runs and form the output bit.
    // The window w is the register contents after this cell's shift.
    always_comb begin
        w[0]         = sym;
        w[1]         = s_q[0];
        w[2]         = s_q[1];
        w[3]         = s_q[2];
        mark         = is_mark(sym);
        sym_neg      = (sym == SYM_NEG);
        is_v         = mark && (sym_neg == last_neg_q);
        v_err        = is_v && (is_mark(w[1]) || is_mark(w[2]) ||
                                (v_seen_q && (last_v_neg_q == sym_neg)));
        s_d          = s_q;
        last_neg_d   = last_neg_q;
        v_seen_d     = v_seen_q;
        last_v_neg_d = last_v_neg_q;
        fill_d       = fill_q;
        zcnt_d       = zcnt_q;
        los_d        = los_q;
        bit_valid_d  = 1'b0;
        bit_data_d   = 1'b0;
        code_err_d   = 1'b0;
        if (sym_valid) begin
            if (is_v) begin
                w[0]         = SYM_ZERO;
                w[3]         = SYM_ZERO;
                v_seen_d     = 1'b1;
                last_v_neg_d = sym_neg;
            end
            if (mark) begin
                last_neg_d = sym_neg;
                zcnt_d     = '0;
                los_d      = 1'b0;
            end else begin
                zcnt_d = (zcnt_q == 8'hFF) ? zcnt_q : zcnt_q + 8'd1;
                if (zcnt_d >= 8'(LOS_ZEROS)) los_d = 1'b1;
            end
            s_d         = w;
            code_err_d  = both_err | v_err;
            fill_d      = (fill_q == 3'd4) ? fill_q : fill_q + 3'd1;
            bit_valid_d = (fill_q >= 3'd3);
            bit_data_d  = (fill_q >= 3'd3) && is_mark(w[3]);
        end
    end

    // Decoder pipeline and status registers.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int unsigned i = 0; i < 4; i++) s_q[i] <= SYM_ZERO;
            last_neg_q   <= 1'b1;
            v_seen_q     <= 1'b0;
            last_v_neg_q <= 1'b0;
            fill_q       <= '0;
            zcnt_q       <= '0;
            los_q        <= 1'b1;
            bit_valid_q  <= 1'b0;
            bit_data_q   <= 1'b0;
            code_err_q   <= 1'b0;
        end else begin
            s_q          <= s_d;
            last_neg_q   <= last_neg_d;
            v_seen_q     <= v_seen_d;
            last_v_neg_q <= last_v_neg_d;
            fill_q       <= fill_d;
            zcnt_q       <= zcnt_d;
            los_q        <= los_d;
            bit_valid_q  <= bit_valid_d;
            bit_data_q   <= bit_data_d;
            code_err_q   <= code_err_d;
        end
    end

    assign bit_valid = bit_valid_q;
    assign bit_data  = bit_data_q;
    assign code_err  = code_err_q;
    assign los       = los_q;

endmodule

// File: doc/e1_rx_hdb3_decoder.md
Name: e1_rx_hdb3_decoder

Overview:
- Receive front-end for the E1 line: takes the raw HDB3 positive/negative pulse inputs (rxp/rxn), runs on the 16.384 MHz host clock (8x the 2.048 Mbit/s line rate) and recovers bit timing.
- Decodes HDB3 to NRZ and emits one data bit per recovered bit cell.
- Flags code errors and loss of signal.
- Sits between the rx pins and the framer/AXI-visible receive logic inside the top BSV design.

Parameters:
- OSR, 8, host clock cycles per bit cell; a power of 2, minimum 4.
- LOS_ZEROS, 32, consecutive zero symbols that assert los; range 10-255.
- SYNC_STAGES, 2, flip-flop depth of each input synchronizer.

Ports:
- CLK  input  1  host clock, 16.384 MHz.
- RST_N  input  1  asynchronous, active-low reset.
- rxp  input  1  positive-mark pulse from line interface; asynchronous to CLK.
- rxn  input  1  negative-mark pulse from line interface; asynchronous to CLK.
- bit_valid  output  1  one-cycle strobe, one per decoded bit.
- bit_data  output  1  decoded NRZ bit; qualified by bit_valid.
- code_err  output  1  one-cycle strobe on a line code error.
- los  output  1  loss of signal, level.

Behaviour:
- Reset: all flops clear asynchronously on RST_N low.
  - Output reset values: bit_valid=0, bit_data=0, code_err=0, los=1.
  - Internal reset values: phase=0, fill count=0, zero counter=0, last-mark polarity=negative (so the first positive mark is not a violation).
  - Reset asserted mid-cell discards the partial cell and the pipeline.
- Synchronizer: SYNC_STAGES flops per input, reset to 0. All logic below uses the synchronized values rp and rn.
- Timing recovery:
  - phase counter runs 0..OSR-1 and wraps.
  - Edge = rising edge of (rp|rn) against the previous cycle. On an edge, phase loads 1; the edge cycle counts as phase 0.
  - Without an edge, phase increments.
  - Flags seen_p and seen_n are set when rp or rn is high during the cell.
- Cell close: at phase==OSR-1, the cell's symbol is formed and both flags clear.
  - seen_p only -> symbol +1.
  - seen_n only -> symbol -1.
  - neither -> symbol 0.
  - both -> symbol 0 and code_err pulses.
  - An edge arriving on the phase==OSR-1 cycle restarts the cell. The closing cell still evaluates first; the edge sample goes to the new cell.
- HDB3 decode:
  - 4-entry symbol shift register s[0..3]; s[0] is newest. It shifts at every cell close.
  - A mark whose polarity equals the last-mark polarity is a violation V. V is written as 0. If s[3] (three cells earlier) is a mark (the B pulse), s[3] is also zeroed before it is output.
  - A mark updates last-mark polarity, including V marks.
  - code_err pulses if a V arrives with either of the two middle entries non-zero.
  - code_err pulses if two consecutive V share polarity, which requires tracking last-V polarity.
- Output:
  - On the cycle after cell close, bit_valid=1 and bit_data=(s[3]!=0), using the post-zeroing value.
  - Latency is 3 cells plus 1 cycle from cell close to output.
  - bit_valid is suppressed until 4 symbols have entered after reset.
- LOS:
  - A zero counter increments on each 0 symbol, saturating at 255. It clears on a mark.
  - los sets when the count reaches LOS_ZEROS and clears on the first mark symbol.
  - Bits still emit during los (as zeros).
- Simultaneous events: a both-polarity cell and a V check in the same close produce a single code_err pulse.

Decomposition:
- Shared package e1_pkg:
  - E1_OSR constant.
  - symbol type enum {SYM_ZERO, SYM_POS, SYM_NEG}.
  - E1_LOS_DEFAULT constant.
- Natural sub-module: e1_rx_bit_sync, covering synchronizers, edge detection, phase counter and symbol formation, with output sym/sym_valid/both_err.
- The top of this block holds the HDB3 pipeline and LOS logic.

Test Plan:
- Reset, then idle lines for 40 cells -> los stays 1; bit_valid appears after 4 cells, all bit_data=0; no code_err.
- AMI pattern +,-,+,- at 4-cycle pulses per 8-cycle cell -> bit_data 1,1,1,1 after 4-cell latency; los drops 1 cycle after the first cell close.
- Sequence +,0,0,0,+ (000V after + mark) -> bits 1,0,0,0,0; no code_err.
- Sequence +,-,0,0,- (B00V) -> bits 1,0,0,0,0; B zeroed; no code_err.
- Pulse asserted on both rxp and rxn in one cell -> exactly one code_err pulse; that bit=0.
- Line clock drifted by one cycle every 16 cells (7- and 9-cycle cells) on an alternating-mark stream -> zero bit slips over 256 bits.
- RST_N pulled low mid-cell -> all outputs return immediately to reset values (los=1, strobes 0); after release, the pipeline refills with 4 cells before bit_valid.
